// File: rtl/robot_motion_monitor.sv
// On-chip motion checker: map bounds, orientation code, single-step moves and stalls,
// with sticky flags, move counter and first-anomaly capture. Optional trace: MONITOR_TRACE_EN.
module robot_motion_monitor #(
  parameter  int ROWS        = 10,
  parameter  int COLS        = 20,
  parameter  int STALL_LIMIT = 8,
  parameter  int CNT_W       = 16,
  parameter  int TRACE_DEPTH = 16,
  localparam int TIW         = $clog2(TRACE_DEPTH)
) (
  input  logic             CLOCK_50,
  input  logic             reset,
  input  logic             sample,
  input  logic [5:0]       robot_row,
  input  logic [5:0]       robot_column,
  input  logic [2:0]       robot_orientation,
  input  logic             clear,
  output logic             anomaly,
  output logic [3:0]       anomaly_flags,
  output logic             first_valid,
  output logic [3:0]       first_code,
  output logic [5:0]       first_row,
  output logic [5:0]       first_col,
  output logic [CNT_W-1:0] move_count,
  input  logic [TIW-1:0]   trace_idx,
  output logic [11:0]      trace_data
);

  localparam int SW = $clog2(STALL_LIMIT);

  logic             anomaly_r;
  logic [3:0]       flags_r;
  logic             first_valid_r;
  logic [3:0]       first_code_r;
  logic [5:0]       first_row_r;
  logic [5:0]       first_col_r;
  logic [CNT_W-1:0] move_count_r;
  logic             prev_valid_r;
  logic [5:0]       prev_row_r;
  logic [5:0]       prev_col_r;
  logic [SW-1:0]    stall_cnt_r;

  logic             accept_s;
  logic             outside_s;
  logic             bad_ori_s;
  logic             same_pos_s;
  logic             moved_s;
  logic             illegal_step_s;
  logic             stall_hit_s;
  logic signed [6:0] drow_s;
  logic signed [6:0] dcol_s;
  logic [6:0]       adrow_s;
  logic [6:0]       adcol_s;
  logic [7:0]       step_dist_s;
  logic [3:0]       fail_s;

  // Per-sample checks evaluated on the current inputs against the stored reference
  always_comb begin
    accept_s   = sample && !clear;
    outside_s  = (robot_row == 6'd0) || (robot_row > 6'(ROWS)) ||
                 (robot_column == 6'd0) || (robot_column > 6'(COLS));
    bad_ori_s  = (robot_orientation > 3'd3);
    drow_s     = $signed({1'b0, robot_row}) - $signed({1'b0, prev_row_r});
    dcol_s     = $signed({1'b0, robot_column}) - $signed({1'b0, prev_col_r});
    if (drow_s[6]) begin
      adrow_s = 7'(-drow_s);
    end else begin
      adrow_s = 7'(drow_s);
    end
    if (dcol_s[6]) begin
      adcol_s = 7'(-dcol_s);
    end else begin
      adcol_s = 7'(dcol_s);
    end
    step_dist_s    = {1'b0, adrow_s} + {1'b0, adcol_s};
    same_pos_s     = prev_valid_r && (robot_row == prev_row_r) && (robot_column == prev_col_r);
    moved_s        = prev_valid_r && !same_pos_s;
    illegal_step_s = prev_valid_r && (step_dist_s > 8'd1);
    // Only the transition into the saturated count raises the stall, so one pulse per episode
    stall_hit_s    = same_pos_s && (stall_cnt_r == SW'(STALL_LIMIT - 2));
    fail_s         = {stall_hit_s, illegal_step_s, bad_ori_s, outside_s};
  end

  // Monitor state: flags, capture, counters and reference position
  always_ff @(posedge CLOCK_50 or negedge reset) begin
    if (!reset) begin
      anomaly_r     <= 1'b0;
      flags_r       <= 4'd0;
      first_valid_r <= 1'b0;
      first_code_r  <= 4'd0;
      first_row_r   <= 6'd0;
      first_col_r   <= 6'd0;
      move_count_r  <= '0;
      prev_valid_r  <= 1'b0;
      prev_row_r    <= 6'd0;
      prev_col_r    <= 6'd0;
      stall_cnt_r   <= '0;
    end else if (clear) begin
      anomaly_r     <= 1'b0;
      flags_r       <= 4'd0;
      first_valid_r <= 1'b0;
      first_code_r  <= 4'd0;
      first_row_r   <= 6'd0;
      first_col_r   <= 6'd0;
      move_count_r  <= '0;
      prev_valid_r  <= 1'b0;
      prev_row_r    <= 6'd0;
      prev_col_r    <= 6'd0;
      stall_cnt_r   <= '0;
    end else if (accept_s) begin
      anomaly_r    <= |fail_s;
      flags_r      <= flags_r | fail_s;
      prev_valid_r <= 1'b1;
      prev_row_r   <= robot_row;
      prev_col_r   <= robot_column;
      if (!first_valid_r && (|fail_s)) begin
        first_valid_r <= 1'b1;
        first_code_r  <= fail_s;
        first_row_r   <= robot_row;
        first_col_r   <= robot_column;
      end else begin
        first_valid_r <= first_valid_r;
      end
      if (moved_s && (move_count_r != {CNT_W{1'b1}})) begin
        move_count_r <= move_count_r + CNT_W'(1);
      end else begin
        move_count_r <= move_count_r;
      end
      if (!same_pos_s) begin
        stall_cnt_r <= '0;
      end else if (stall_cnt_r != SW'(STALL_LIMIT - 1)) begin
        stall_cnt_r <= stall_cnt_r + SW'(1);
      end else begin
        stall_cnt_r <= stall_cnt_r;
      end
    end else begin
      anomaly_r <= 1'b0;
    end
  end

  assign anomaly       = anomaly_r;
  assign anomaly_flags = flags_r;
  assign first_valid   = first_valid_r;
  assign first_code    = first_code_r;
  assign first_row     = first_row_r;
  assign first_col     = first_col_r;
  assign move_count    = move_count_r;

`ifdef MONITOR_TRACE_EN
  logic [11:0]  trace_mem_r [TRACE_DEPTH];
  logic [TIW-1:0] wp_r;
  logic [TIW:0]   fill_r;
  logic [11:0]    trace_data_r;
  logic [TIW-1:0] rd_ptr_s;

  assign rd_ptr_s = wp_r - TIW'(1) - trace_idx;

  // Trace storage; unwritten slots are masked by the fill count, so no reset is needed
  always_ff @(posedge CLOCK_50) begin
    if (accept_s) begin
      trace_mem_r[wp_r] <= {robot_row, robot_column};
    end
  end

  // Trace write pointer, fill count and registered read port
  always_ff @(posedge CLOCK_50 or negedge reset) begin
    if (!reset) begin
      wp_r         <= '0;
      fill_r       <= '0;
      trace_data_r <= 12'd0;
    end else if (clear) begin
      wp_r         <= '0;
      fill_r       <= '0;
      trace_data_r <= 12'd0;
    end else begin
      if (accept_s) begin
        wp_r <= wp_r + TIW'(1);
        if (fill_r != (TIW+1)'(TRACE_DEPTH)) begin
          fill_r <= fill_r + (TIW+1)'(1);
        end else begin
          fill_r <= fill_r;
        end
      end else begin
        wp_r <= wp_r;
      end
      if ({1'b0, trace_idx} < fill_r) begin
        trace_data_r <= trace_mem_r[rd_ptr_s];
      end else begin
        trace_data_r <= 12'd0;
      end
    end
  end

  assign trace_data = trace_data_r;
`else
  logic unused_trace_idx_s;
  assign unused_trace_idx_s = ^trace_idx;
  assign trace_data         = 12'd0;
`endif

endmodule

// File: tb/tb_robot_motion_monitor.sv
// Directed self-checking bench for robot_motion_monitor (ROWS=10, COLS=20, STALL_LIMIT=8,
// CNT_W=4 to reach saturation, TRACE_DEPTH=4).
module tb_robot_motion_monitor;

  logic        clk;
  logic        reset;
  logic        sample;
  logic [5:0]  row;
  logic [5:0]  col;
  logic [2:0]  ori;
  logic        clear;
  logic        anomaly;
  logic [3:0]  flags;
  logic        first_valid;
  logic [3:0]  first_code;
  logic [5:0]  first_row;
  logic [5:0]  first_col;
  logic [3:0]  move_count;
  logic [1:0]  trace_idx;
  logic [11:0] trace_data;

  int n_checks = 0;
  int n_pass   = 0;
  int pulses;

  robot_motion_monitor #(
    .ROWS(10), .COLS(20), .STALL_LIMIT(8), .CNT_W(4), .TRACE_DEPTH(4)
  ) dut (
    .CLOCK_50(clk), .reset(reset), .sample(sample),
    .robot_row(row), .robot_column(col), .robot_orientation(ori),
    .clear(clear), .anomaly(anomaly), .anomaly_flags(flags),
    .first_valid(first_valid), .first_code(first_code),
    .first_row(first_row), .first_col(first_col),
    .move_count(move_count), .trace_idx(trace_idx), .trace_data(trace_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) begin
      n_pass++;
    end else begin
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic smp(input logic [5:0] r, input logic [5:0] c, input logic [2:0] o);
    @(negedge clk);
    row = r; col = c; ori = o; sample = 1'b1;
    @(negedge clk);
    sample = 1'b0;
  endtask

  task automatic do_clear();
    @(negedge clk);
    clear = 1'b1;
    @(negedge clk);
    clear = 1'b0;
  endtask

  initial begin
    reset = 1'b0; clear = 1'b0; sample = 1'b0;
    row = 6'd0; col = 6'd0; ori = 3'd0; trace_idx = 2'd0;
    repeat (4) @(posedge clk);
    @(negedge clk);
    chk("rst_anomaly", anomaly, 1'b0);
    chk("rst_flags", flags, 4'd0);
    chk("rst_first", {first_valid, first_code, first_row, first_col}, 17'd0);
    chk("rst_moves", move_count, 4'd0);
    chk("rst_trace", trace_data, 12'd0);
    reset = 1'b1;

    // First sample only loads the reference
    smp(6'd1, 6'd1, 3'd2);
    chk("first_anomaly", anomaly, 1'b0);
    chk("first_flags", flags, 4'd0);
    chk("first_moves", move_count, 4'd0);
    chk("first_valid0", first_valid, 1'b0);

    // Legal moves plus a turn in place
    smp(6'd1, 6'd2, 3'd2);
    smp(6'd2, 6'd2, 3'd2);
    smp(6'd2, 6'd2, 3'd3);
    chk("legal_moves", move_count, 4'd2);
    chk("legal_flags", flags, 4'd0);
    chk("turn_anomaly", anomaly, 1'b0);

    // Diagonal step
    do_clear();
    smp(6'd3, 6'd3, 3'd2);
    chk("diag_ref", anomaly, 1'b0);
    smp(6'd4, 6'd4, 3'd2);
    chk("diag_anomaly", anomaly, 1'b1);
    chk("diag_flags", flags, 4'b0100);
    chk("diag_fvalid", first_valid, 1'b1);
    chk("diag_fcode", first_code, 4'b0100);
    chk("diag_frow", first_row, 6'd4);
    chk("diag_fcol", first_col, 6'd4);
    chk("diag_moves", move_count, 4'd1);

    do_clear();
    chk("clr_flags", flags, 4'd0);
    chk("clr_first", {first_valid, first_code, first_row, first_col}, 17'd0);
    chk("clr_moves", move_count, 4'd0);

    // Outside map and bad orientation together, then a jump that keeps the capture
    smp(6'd11, 6'd5, 3'd5);
    chk("oob_anomaly", anomaly, 1'b1);
    chk("oob_fcode", first_code, 4'b0011);
    chk("oob_frow", first_row, 6'd11);
    chk("oob_fcol", first_col, 6'd5);
    smp(6'd0, 6'd0, 3'd0);
    chk("jump_anomaly", anomaly, 1'b1);
    chk("jump_flags", flags, 4'b0111);
    chk("jump_fcode", first_code, 4'b0011);
    chk("jump_frow", first_row, 6'd11);

    // Stall: eight identical samples raise the flag once
    do_clear();
    pulses = 0;
    for (int i = 1; i <= 8; i++) begin
      smp(6'd5, 6'd5, 3'd0);
      pulses += int'(anomaly);
      if (i == 7) chk("stall_pre_flags", flags, 4'd0);
    end
    chk("stall_flags", flags, 4'b1000);
    chk("stall_anomaly8", anomaly, 1'b1);
    chk("stall_pulses", pulses, 1);
    smp(6'd5, 6'd5, 3'd0);
    chk("stall_anomaly9", anomaly, 1'b0);
    chk("stall_flags9", flags, 4'b1000);
    chk("stall_fcode", first_code, 4'b1000);
    chk("stall_moves", move_count, 4'd0);

    // Map edge
    do_clear();
    smp(6'd10, 6'd20, 3'd1);
    chk("edge_in", anomaly, 1'b0);
    smp(6'd10, 6'd21, 3'd1);
    chk("edge_out", anomaly, 1'b1);
    chk("edge_flags", flags, 4'b0001);
    chk("edge_fcol", first_col, 6'd21);

    // clear wins over a simultaneous sample
    do_clear();
    smp(6'd3, 6'd3, 3'd0);
    @(negedge clk);
    clear = 1'b1; sample = 1'b1; row = 6'd9; col = 6'd9;
    @(negedge clk);
    clear = 1'b0; sample = 1'b0;
    smp(6'd3, 6'd4, 3'd0);
    chk("prio_anomaly", anomaly, 1'b0);
    chk("prio_flags", flags, 4'd0);
    chk("prio_moves", move_count, 4'd0);

    // move_count saturation (CNT_W=4)
    do_clear();
    for (int c = 1; c <= 18; c++) smp(6'd1, 6'(c), 3'd2);
    chk("sat_moves", move_count, 4'd15);
    chk("sat_flags", flags, 4'd0);

    // Asynchronous reset mid-run; next sample is a first sample
    smp(6'd5, 6'd5, 3'd0);
    chk("pre_rst_flags", flags, 4'b0100);
    #2 reset = 1'b0;
    #1;
    chk("async_flags", flags, 4'd0);
    chk("async_moves", move_count, 4'd0);
    chk("async_fvalid", first_valid, 1'b0);
    @(negedge clk);
    reset = 1'b1;
    smp(6'd7, 6'd7, 3'd0);
    chk("post_rst_anomaly", anomaly, 1'b0);
    chk("post_rst_flags", flags, 4'd0);

`ifdef MONITOR_TRACE_EN
    do_clear();
    for (int c = 1; c <= 6; c++) smp(6'd1, 6'(c), 3'd2);
    for (int i = 0; i < 4; i++) begin
      trace_idx = 2'(i);
      @(negedge clk);
      chk("trace_rd", trace_data, {6'd1, 6'(6 - i)});
    end
    do_clear();
    smp(6'd2, 6'd3, 3'd0);
    trace_idx = 2'd0;
    @(negedge clk);
    chk("trace_one", trace_data, {6'd2, 6'd3});
    trace_idx = 2'd1;
    @(negedge clk);
    chk("trace_unwritten", trace_data, 12'd0);
    trace_idx = 2'd0;
    do_clear();
    @(negedge clk);
    chk("trace_clr", trace_data, 12'd0);
    chk("trace_clr_moves", move_count, 4'd0);
    chk("trace_clr_flags", flags, 4'd0);
`else
    trace_idx = 2'd2;
    @(negedge clk);
    chk("trace_off", trace_data, 12'd0);
`endif

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
